mdu_seq: RTL and testbench

MDU_SEQ -- requirements
Module: mdu_seq

---
 rtl/mdu_pkg.sv | 36 +++
 rtl/mdu_div.sv | 36 +++
 rtl/mdu_seq.sv | 177 +++++++++++++++++
 tb/tb_mdu_seq.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types for the sequential multiply/divide unit.
//   mdu_op_e    - MDUctrl operation encoding
//   mdu_state_e - control FSM states (IDLE -> RUN -> FIX -> IDLE)
// The helper functions give operand signedness and the op class for an encoding.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } mdu_state_e;

  function automatic logic op1_signed(input mdu_op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic op2_signed(input mdu_op_e op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

  function automatic logic is_div(input mdu_op_e op);
    return op[2];
  endfunction

endpackage

// File: rtl/mdu_div.sv
// mdu_div: one restoring-division step on unsigned magnitudes (combinational).
// Only compiled when MDU_DIV_EN is defined.
//   rem     - partial remainder (always < dvs)
//   quo     - dividend bits still to shift in / quotient bits shifted out
//   dvs     - divisor magnitude
//   rem_nxt - partial remainder after this step
//   quo_nxt - quo shifted left with the new quotient bit in bit 0
`ifdef MDU_DIV_EN
module mdu_div #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rem,
  input  logic [DATA_WIDTH-1:0] quo,
  input  logic [DATA_WIDTH-1:0] dvs,
  output logic [DATA_WIDTH-1:0] rem_nxt,
  output logic [DATA_WIDTH-1:0] quo_nxt
);

  logic [DATA_WIDTH:0] shifted;
  logic [DATA_WIDTH:0] diff;

  always_comb begin
    shifted = {rem, quo[DATA_WIDTH-1]};
    diff    = shifted - {1'b0, dvs};
    // shifted < 2*dvs, so diff's top bit is its sign: set means "restore".
    if (!diff[DATA_WIDTH]) begin
      rem_nxt = diff[DATA_WIDTH-1:0];
      quo_nxt = {quo[DATA_WIDTH-2:0], 1'b1};
    end else begin
      rem_nxt = shifted[DATA_WIDTH-1:0];
      quo_nxt = {quo[DATA_WIDTH-2:0], 1'b0};
    end
  end

endmodule
`endif

// File: rtl/mdu_seq.sv
// mdu_seq: sequential RV-style multiply/divide unit, one bit per cycle.
// Divide hardware is present only when MDU_DIV_EN is defined; otherwise the
// divide/remainder ops complete one cycle after start with MDUout = 0.
//   clk, rst_n - rising-edge clock, asynchronous active-low reset
//   start      - request, sampled only in IDLE
//   MDUctrl    - operation (see mdu_pkg::mdu_op_e)
//   MDUop1/2   - rs1 / rs2 operands
//   busy       - high while an op is in flight
//   done       - one-cycle pulse when MDUout is updated
//   MDUout     - registered result, held until the next done
module mdu_seq #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2:0]            MDUctrl,
  input  logic [DATA_WIDTH-1:0] MDUop1,
  input  logic [DATA_WIDTH-1:0] MDUop2,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] MDUout
);

  import mdu_pkg::*;

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);

  mdu_state_e     state;
  mdu_op_e        op;
  logic [CW-1:0]  cnt;
  logic [2*W-1:0] acc;      // multiply: product/multiplier; divide: {rem, quo}
  logic [W-1:0]   opb;      // multiplicand or divisor magnitude
  logic           neg_res;  // product / quotient must be negated in FIX
  logic           bypass;   // acc[W-1:0] already holds the final result
`ifdef MDU_DIV_EN
  logic           neg_rem;
`endif

  // Request decode (only meaningful in IDLE).
  mdu_op_e        req_op;
  logic           neg1, neg2, req_bypass;
  logic [W-1:0]   mag1, mag2, spec_res;

  assign req_op = mdu_op_e'(MDUctrl);

  always_comb begin
    neg1 = op1_signed(req_op) & MDUop1[W-1];
    neg2 = op2_signed(req_op) & MDUop2[W-1];
    mag1 = neg1 ? -MDUop1 : MDUop1;
    mag2 = neg2 ? -MDUop2 : MDUop2;
`ifdef MDU_DIV_EN
    spec_res   = '0;
    req_bypass = 1'b0;
    if (is_div(req_op)) begin
      if (MDUop2 == '0) begin
        req_bypass = 1'b1;
        spec_res   = (req_op inside {OP_DIV, OP_DIVU}) ? '1 : MDUop1;
      end else if ((req_op inside {OP_DIV, OP_REM}) &&
                   (MDUop1 == {1'b1, {(W-1){1'b0}}}) && (MDUop2 == '1)) begin
        req_bypass = 1'b1;
        spec_res   = (req_op == OP_DIV) ? MDUop1 : '0;
      end
    end
`else
    spec_res   = '0;
    req_bypass = is_div(req_op);
`endif
  end

  // Shift-add multiply step: add multiplicand into the top half, shift right.
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_nxt;

  always_comb begin
    mul_sum = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opb} : '0);
    mul_nxt = {mul_sum, acc[W-1:1]};
  end

`ifdef MDU_DIV_EN
  logic [W-1:0] div_rem, div_quo;

  mdu_div #(
    .DATA_WIDTH (W)
  ) u_div (
    .rem     (acc[2*W-1:W]),
    .quo     (acc[W-1:0]),
    .dvs     (opb),
    .rem_nxt (div_rem),
    .quo_nxt (div_quo)
  );
`endif

  // Sign correction and result selection.
  logic [2*W-1:0] prod;
  logic [W-1:0]   fix_res;

  always_comb begin
    prod    = neg_res ? -acc : acc;
    fix_res = '0;
    if (bypass) begin
      fix_res = acc[W-1:0];
    end else if (!is_div(op)) begin
      fix_res = (op == OP_MUL) ? prod[W-1:0] : prod[2*W-1:W];
    end
`ifdef MDU_DIV_EN
    else if (op[1]) begin
      fix_res = neg_rem ? -acc[2*W-1:W] : acc[2*W-1:W];
    end else begin
      fix_res = neg_res ? -acc[W-1:0] : acc[W-1:0];
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      op      <= OP_MUL;
      cnt     <= '0;
      acc     <= '0;
      opb     <= '0;
      neg_res <= 1'b0;
      bypass  <= 1'b0;
`ifdef MDU_DIV_EN
      neg_rem <= 1'b0;
`endif
      busy    <= 1'b0;
      done    <= 1'b0;
      MDUout  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            op      <= req_op;
            neg_res <= neg1 ^ neg2;
`ifdef MDU_DIV_EN
            neg_rem <= neg1;
`endif
            cnt     <= '0;
            busy    <= 1'b1;
            bypass  <= req_bypass;
            if (req_bypass) begin
              acc   <= {{W{1'b0}}, spec_res};
              opb   <= '0;
              state <= ST_FIX;
            end else begin
              // Divide shifts the dividend out of acc; multiply shifts the multiplier.
              acc   <= {{W{1'b0}}, is_div(req_op) ? mag1 : mag2};
              opb   <= is_div(req_op) ? mag2 : mag1;
              state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
`ifdef MDU_DIV_EN
          acc <= is_div(op) ? {div_rem, div_quo} : mul_nxt;
`else
          acc <= mul_nxt;
`endif
          cnt <= cnt + 1'b1;
          if (cnt == CW'(W - 1)) state <= ST_FIX;
        end
        ST_FIX: begin
          MDUout <= fix_res;
          done   <= 1'b1;
          busy   <= 1'b0;
          cnt    <= '0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: directed scoreboard bench for mdu_seq (DATA_WIDTH = 32).
// Divide expectations follow MDU_DIV_EN: real results when defined,
// otherwise 0 one cycle after start.
module tb_mdu_seq;

  localparam int W = 32;
`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   MDUctrl = 3'b000;
  logic [W-1:0] MDUop1 = '0;
  logic [W-1:0] MDUop2 = '0;
  logic         busy, done;
  logic [W-1:0] MDUout;

  mdu_seq #(.DATA_WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .MDUctrl (MDUctrl),
    .MDUop1  (MDUop1),
    .MDUop2  (MDUop2),
    .busy    (busy),
    .done    (done),
    .MDUout  (MDUout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    int           due;
    string        name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   passes = 0;

  task automatic check(input string nm, input longint act, input longint req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, req);
  endtask

  // Monitor: every done pulse is matched against the oldest pending op.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no pending op", cyc);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.name, "_result"}, MDUout, mon_e.res);
        check({mon_e.name, "_latency"}, cyc, mon_e.due);
        check({mon_e.name, "_busy_at_done"}, busy, 0);
      end
    end
  end

  // Called at a negedge; the next posedge samples start.
  task automatic issue(input string nm, input logic [2:0] ctl, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] res, input int lat);
    exp_t e;
    MDUctrl = ctl;
    MDUop1  = a;
    MDUop2  = b;
    start   = 1'b1;
    e.res   = res;
    e.due   = cyc + 1 + lat;
    e.name  = nm;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic div_op(input string nm, input logic [2:0] ctl, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] res, input int lat);
    if (DIV_EN) issue(nm, ctl, a, b, res, lat);
    else        issue(nm, ctl, a, b, '0, 1);
  endtask

  // Returns at the negedge where done is high.
  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      $display("FAIL %s_timeout: got no done within 200 cycles, expected done", nm);
    end
  endtask

  initial begin
    int nd;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_mduout", MDUout, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // MUL 7 x 6, 33-cycle latency, busy during op
    issue("mul_7x6", 3'b000, 32'd7, 32'd6, 32'd42, 33);
    check("busy_in_flight", busy, 1);
    wait_done("mul_7x6");
    @(negedge clk);
    check("done_is_pulse", done, 0);
    check("mduout_held", MDUout, 32'd42);

    // Multiply variants, issued back-to-back in each done cycle
    issue("mulhu_max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    wait_done("mulhu_max");
    issue("mulh_m1m1", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
    wait_done("mulh_m1m1");
    issue("mulhsu_m1x2", 3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 33);
    wait_done("mulhsu_m1x2");
    issue("mulh_minmin", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    wait_done("mulh_minmin");
    issue("mulhu_2p33", 3'b011, 32'h8000_0000, 32'h0000_0004, 32'h0000_0002, 33);
    wait_done("mulhu_2p33");

    // DIV then REM back-to-back, start held high in the done cycle
    div_op("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    wait_done("div_m7_2");
    div_op("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    wait_done("rem_m7_2");
    div_op("div_7_m2", 3'b100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
    wait_done("div_7_m2");
    div_op("rem_7_m2", 3'b110, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);
    wait_done("rem_7_m2");
    div_op("divu_100_7", 3'b101, 32'd100, 32'd7, 32'd14, 33);
    wait_done("divu_100_7");
    div_op("remu_100_7", 3'b111, 32'd100, 32'd7, 32'd2, 33);
    wait_done("remu_100_7");

    // Special cases: done one edge after start
    div_op("divu_5_0", 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    wait_done("divu_5_0");
    div_op("remu_5_0", 3'b111, 32'd5, 32'd0, 32'd5, 1);
    wait_done("remu_5_0");
    div_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    wait_done("div_ovf");
    div_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
    wait_done("rem_ovf");
    div_op("div_m5_0", 3'b100, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 1);
    wait_done("div_m5_0");
    div_op("rem_m5_0", 3'b110, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1);
    wait_done("rem_m5_0");

    // Start while busy, with different operands, must be ignored
    @(negedge clk);
    issue("mul_ignore", 3'b000, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 33);
    repeat (3) @(negedge clk);
    MDUctrl = 3'b011;
    MDUop1  = 32'hFFFF_FFFF;
    MDUop2  = 32'hFFFF_FFFF;
    start   = 1'b1;
    repeat (5) @(negedge clk);
    start   = 1'b0;
    wait_done("mul_ignore");
    repeat (40) @(negedge clk);

    // Reset 10 cycles into a MUL: immediate clear, no done afterwards
    issue("mul_abort", 3'b000, 32'd7, 32'd6, 32'd42, 33);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_mduout", MDUout, 0);
    check("abort_done", done, 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("abort_no_done", nd, 0);

    // Recovery after reset
    issue("mul_low_max", 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33);
    wait_done("mul_low_max");
    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish by 400000, expected finish");
    $fatal(1);
  end

endmodule
